// File: rtl/adder_pkg.sv
// Shared helpers and stage flag bundle for the chunked pipelined adder.
// Define PIPE_ADDER_OVF_EN to build the signed-overflow flag path.
package adder_pkg;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit split_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
`ifdef PIPE_ADDER_OVF_EN
        logic ovf;
`endif
    } stage_flags_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple adder for one chunk; also exposes the carry into
// the slice MSB so the top slice can form the signed overflow flag.
module adder_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic carry;
        carry    = cin;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1)
                c_msb_in = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit ripple per stage.
// Define PIPE_ADDER_OVF_EN to compute and pipeline the ovf flag.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    typedef struct packed {
        stage_flags_t     f;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic              advance;
    logic [STAGES-1:0] c_msb;
    stage_t            head;
    stage_t            regs [STAGES];
    stage_t            last;

    // Subtract is folded in here so the stages only ever add.
    always_comb begin
        head         = '0;
        head.f.valid = in_valid;
        head.f.carry = sub | Cin;
        head.a       = A;
        head.b       = sub ? ~B : B;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        stage_t           src;
        stage_t           nxt;
        stage_t           q;
        logic [CHUNK-1:0] s_k;
        logic             co_k;

        if (k == 0) begin : g_head
            assign src = head;
        end else begin : g_link
            assign src = regs[k-1];
        end

        adder_slice #(
            .WIDTH(CHUNK)
        ) u_slice (
            .a       (src.a[k*CHUNK +: CHUNK]),
            .b       (src.b[k*CHUNK +: CHUNK]),
            .cin     (src.f.carry),
            .s       (s_k),
            .cout    (co_k),
            .c_msb_in(c_msb[k])
        );

        always_comb begin
            nxt                        = src;
            nxt.sum[k*CHUNK +: CHUNK]  = s_k;
            nxt.f.carry                = co_k;
`ifdef PIPE_ADDER_OVF_EN
            nxt.f.ovf = (k == STAGES - 1) ? (c_msb[k] ^ co_k) : 1'b0;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (advance)
                q <= nxt;
        end

        assign regs[k] = q;
    end

    assign last      = regs[STAGES-1];
    assign out_valid = last.f.valid;
    assign S         = last.sum;
    assign Cout      = last.f.carry;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

`ifdef PIPE_ADDER_OVF_EN
    assign ovf = last.f.ovf;
`else
    assign ovf = 1'b0;
`endif

    // Operand copies in the final register have no consumer.
    logic unused_tail;
    assign unused_tail = ^{c_msb, last.a, last.b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, random
// streams, backpressure, sparse traffic and mid-stream reset.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int ST = 4;
`ifdef PIPE_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         Cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;

    int           n_tests   = 0;
    int           n_fail    = 0;
    logic [33:0]  exp_q[$];
    int           run_len   = 0;
    int           max_run   = 0;
    int           stall_n   = 0;
    bit           rand_ready = 1'b0;

    pipelined_adder #(
        .WIDTH (W),
        .STAGES(ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .Cout     (Cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [33:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic c, input logic s);
        logic [31:0] bb;
        logic [32:0] full;
        logic        v;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, (s ? 1'b1 : c)};
        v    = (a[31] == bb[31]) && (full[31] != a[31]) && OVF_ON;
        return {v, full[32], full[31:0]};
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("sum", S, e[31:0]);
                    check("cout", Cout, e[32]);
                    check("ovf", ovf, e[33]);
                end else begin
                    stall_n++;
                    e = exp_q[0];
                    check("bp_in_ready", in_ready, 0);
                    check("bp_hold", S, e[31:0]);
                end
            end
            if (out_valid && out_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(A, B, Cin, sub));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s);
        A        = a;
        B        = b;
        Cin      = c;
        sub      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom % 2);
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic send_rand();
        send($urandom, $urandom, 1'($urandom % 2), 1'($urandom % 2));
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic s,
                            input logic [31:0] es, input logic ec,
                            input logic ev);
        send(a, b, c, s);
        in_valid = 1'b0;
        for (int i = 1; i <= ST; i++) begin
            @(negedge clk);
            if (i < ST) check("lat_early", out_valid, 0);
        end
        check("lat_valid", out_valid, 1);
        check("d_sum", S, es);
        check("d_cout", Cout, ec);
        check("d_ovf", ovf, ev);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_s", S, 0);
        check("rst_cout", Cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0,
                 OVF_ON);
        directed(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        max_run = 0;
        for (int i = 0; i < 16; i++) send_rand();
        in_valid = 1'b0;
        drain();
        check("b2b_run", 64'(max_run), 16);

        stall_n   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < ST; i++) send_rand();
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 4; i++) send_rand();
        in_valid = 1'b0;
        drain();
        check("stall_cycles", 64'(stall_n), 3);

        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            repeat (2) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom % 2);
            end
            send_rand();
            in_valid = 1'b0;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_s", S, 0);
        check("mid_rst_cout", Cout, 0);
        check("mid_rst_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed(32'd1234, 32'd4321, 1'b0, 1'b0, 32'd5555, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
